// File: rtl/ahb_apb_beat_splitter.sv
// Splits one AHB transfer request (one-hot byte length 1..32) into 32-bit APB beats.
// Optional macro SPLITTER_ERR_EN: reject non-one-hot lengths and pulse LEN_ERR instead of issuing a beat.
module ahb_apb_beat_splitter (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [31:0] REQ_ADDR,
  input  logic [5:0]  REQ_LENGTH,
  input  logic        REQ_WRITE,
  output logic        BEAT_VALID,
  input  logic        BEAT_READY,
  output logic [31:0] BEAT_ADDR,
  output logic [3:0]  BEAT_STRB,
  output logic        BEAT_WRITE,
  output logic        BEAT_LAST,
  output logic [2:0]  BEAT_INDEX,
`ifdef SPLITTER_ERR_EN
  output logic        LEN_ERR,
`endif
  output logic        BUSY
);

  localparam logic S_IDLE  = 1'b0;
  localparam logic S_ISSUE = 1'b1;

  logic        r_state, w_state_nxt;
  logic [31:0] r_addr, w_addr_nxt;
  logic [3:0]  r_strb, w_strb_nxt;
  logic        r_write, w_write_nxt;
  logic        r_last, w_last_nxt;
  logic [2:0]  r_index, w_index_nxt;
  logic [2:0]  r_remain, w_remain_nxt;
  logic        r_req_ready, r_beat_valid, r_busy;
  logic        r_len_err, w_len_err_nxt;
  logic        w_load;

  logic        w_len_ok;
  logic [5:0]  w_len_eff;
  logic [3:0]  w_req_strb;
  logic [2:0]  w_req_remain;

  // Request decode: invalid lengths fall back to a single byte
  always_comb begin
    w_len_ok  = (REQ_LENGTH != 6'd0) && ((REQ_LENGTH & (REQ_LENGTH - 6'd1)) == 6'd0);
    w_len_eff = w_len_ok ? REQ_LENGTH : 6'd1;
    if (w_len_eff[0])
      w_req_strb = 4'b0001 << REQ_ADDR[1:0];
    else if (w_len_eff[1])
      w_req_strb = 4'b0011 << {REQ_ADDR[1], 1'b0};
    else
      w_req_strb = 4'b1111;
    if (w_len_eff[5])
      w_req_remain = 3'd7;
    else if (w_len_eff[4])
      w_req_remain = 3'd3;
    else if (w_len_eff[3])
      w_req_remain = 3'd1;
    else
      w_req_remain = 3'd0;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_addr_nxt    = r_addr;
    w_strb_nxt    = r_strb;
    w_write_nxt   = r_write;
    w_last_nxt    = r_last;
    w_index_nxt   = r_index;
    w_remain_nxt  = r_remain;
    w_len_err_nxt = 1'b0;
    w_load        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (REQ_VALID) begin
`ifdef SPLITTER_ERR_EN
          if (!w_len_ok)
            w_len_err_nxt = 1'b1;
          else
            w_load = 1'b1;
`else
          w_load = 1'b1;
`endif
        end
        if (w_load) begin
          w_state_nxt  = S_ISSUE;
          w_addr_nxt   = {REQ_ADDR[31:2], 2'b00};
          w_strb_nxt   = w_req_strb;
          w_write_nxt  = REQ_WRITE;
          w_index_nxt  = 3'd0;
          w_remain_nxt = w_req_remain;
          w_last_nxt   = (w_req_remain == 3'd0);
        end
      end
      S_ISSUE: begin
        if (BEAT_READY) begin
          if (r_remain == 3'd0) begin
            w_state_nxt = S_IDLE;
            w_last_nxt  = 1'b0;
          end else begin
            w_addr_nxt   = r_addr + 32'd4;
            w_index_nxt  = r_index + 3'd1;
            w_remain_nxt = r_remain - 3'd1;
            w_last_nxt   = (r_remain == 3'd1);
          end
        end
      end
    endcase
  end

  // Handshake flags are registered copies of the next state so no input reaches an output combinationally
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state      <= S_IDLE;
      r_addr       <= 32'd0;
      r_strb       <= 4'd0;
      r_write      <= 1'b0;
      r_last       <= 1'b0;
      r_index      <= 3'd0;
      r_remain     <= 3'd0;
      r_req_ready  <= 1'b1;
      r_beat_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_len_err    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_addr       <= w_addr_nxt;
      r_strb       <= w_strb_nxt;
      r_write      <= w_write_nxt;
      r_last       <= w_last_nxt;
      r_index      <= w_index_nxt;
      r_remain     <= w_remain_nxt;
      r_req_ready  <= (w_state_nxt == S_IDLE);
      r_beat_valid <= (w_state_nxt == S_ISSUE);
      r_busy       <= (w_state_nxt == S_ISSUE);
      r_len_err    <= w_len_err_nxt;
    end
  end

  assign REQ_READY  = r_req_ready;
  assign BEAT_VALID = r_beat_valid;
  assign BUSY       = r_busy;
  assign BEAT_ADDR  = r_addr;
  assign BEAT_STRB  = r_strb;
  assign BEAT_WRITE = r_write;
  assign BEAT_LAST  = r_last;
  assign BEAT_INDEX = r_index;
`ifdef SPLITTER_ERR_EN
  assign LEN_ERR    = r_len_err;
`else
  logic w_unused;
  assign w_unused = r_len_err;
`endif

endmodule

// File: tb/tb_ahb_apb_beat_splitter.sv
// Bench for ahb_apb_beat_splitter: directed vector table, reset-abort sequence and randomized requests vs. a byte-range model.
module tb_ahb_apb_beat_splitter;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        REQ_VALID, REQ_READY, REQ_WRITE;
  logic [31:0] REQ_ADDR;
  logic [5:0]  REQ_LENGTH;
  logic        BEAT_VALID, BEAT_READY, BEAT_WRITE, BEAT_LAST, BUSY;
  logic [31:0] BEAT_ADDR;
  logic [3:0]  BEAT_STRB;
  logic [2:0]  BEAT_INDEX;
`ifdef SPLITTER_ERR_EN
  logic        LEN_ERR;
`endif

  always #5 HCLK = ~HCLK;

  ahb_apb_beat_splitter dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_ADDR(REQ_ADDR),
    .REQ_LENGTH(REQ_LENGTH), .REQ_WRITE(REQ_WRITE),
    .BEAT_VALID(BEAT_VALID), .BEAT_READY(BEAT_READY), .BEAT_ADDR(BEAT_ADDR),
    .BEAT_STRB(BEAT_STRB), .BEAT_WRITE(BEAT_WRITE), .BEAT_LAST(BEAT_LAST),
    .BEAT_INDEX(BEAT_INDEX),
`ifdef SPLITTER_ERR_EN
    .LEN_ERR(LEN_ERR),
`endif
    .BUSY(BUSY)
  );

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  strb;
  } beat_t;
  beat_t exp_q[$];

  typedef struct {
    logic [31:0] addr;
    logic [5:0]  len;
    logic        write;
    int          mode;
    logic [31:0] exp_first;
    logic [31:0] exp_last_addr;
    logic [3:0]  exp_strb;
    int          exp_beats;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  // Model: the request covers a byte range; beats are the 4-byte words touching it
  function automatic void build(input logic [31:0] a, input logic [5:0] l);
    int eff, n;
    logic [31:0] base, al;
    logic [3:0] s;
    exp_q.delete();
`ifdef SPLITTER_ERR_EN
    if ($countones(l) != 1) return;
`endif
    eff  = ($countones(l) == 1) ? int'(l) : 1;
    n    = (eff >= 4) ? eff / 4 : 1;
    base = a & ~32'h3;
    if (eff >= 4) s = 4'hF;
    else begin
      al = a & ~32'(eff - 1);
      s  = 4'(((1 << eff) - 1) << al[1:0]);
    end
    for (int i = 0; i < n; i++) exp_q.push_back('{addr: base + 32'(4 * i), strb: s});
  endfunction

  task automatic run_req(input logic [31:0] a, input logic [5:0] l, input logic w,
                         input int mode, input int abort_after, input string tag,
                         output logic [31:0] f_addr, output logic [31:0] l_addr,
                         output logic [3:0] f_strb, output int got);
    int cyc, n;
    logic rdy, v, held;
    logic [38:0] snap;
    build(a, l);
    n = exp_q.size();
    f_addr = 32'd0; l_addr = 32'd0; f_strb = 4'd0; got = 0;
    chk({tag, " req_ready_idle"}, 32'(REQ_READY), 32'd1);
    REQ_VALID = 1'b1; REQ_ADDR = a; REQ_LENGTH = l; REQ_WRITE = w; BEAT_READY = 1'b0;
    tick();
    REQ_VALID = 1'b0; REQ_ADDR = $urandom; REQ_LENGTH = 6'($urandom); REQ_WRITE = ~w;
    if (n == 0) begin
`ifdef SPLITTER_ERR_EN
      chk({tag, " err_pulse"}, 32'(LEN_ERR), 32'd1);
      chk({tag, " err_no_valid"}, 32'(BEAT_VALID), 32'd0);
      chk({tag, " err_ready"}, 32'(REQ_READY), 32'd1);
      tick();
      chk({tag, " err_pulse_end"}, 32'(LEN_ERR), 32'd0);
      chk({tag, " err_still_idle"}, 32'(BEAT_VALID), 32'd0);
`endif
      return;
    end
    chk({tag, " first_valid"}, 32'(BEAT_VALID), 32'd1);
    chk({tag, " busy"}, 32'(BUSY), 32'd1);
    chk({tag, " req_ready_low"}, 32'(REQ_READY), 32'd0);
    cyc = 0; held = 1'b0; snap = '0;
    while (got < n && cyc < 200) begin
      v = BEAT_VALID;
      if (v) begin
        if (got == 0) begin f_addr = BEAT_ADDR; f_strb = BEAT_STRB; end
        l_addr = BEAT_ADDR;
        chk({tag, " addr"}, BEAT_ADDR, exp_q[got].addr);
        chk({tag, " strb"}, 32'(BEAT_STRB), 32'(exp_q[got].strb));
        chk({tag, " index"}, 32'(BEAT_INDEX), 32'(got));
        chk({tag, " last"}, 32'(BEAT_LAST), 32'(got == n - 1));
        chk({tag, " write"}, 32'(BEAT_WRITE), 32'(w));
        if (held) chk({tag, " stable"}, 32'({BEAT_ADDR[31:2], BEAT_STRB, BEAT_INDEX}), 32'(snap));
      end else chk({tag, " valid_held"}, 32'(v), 32'd1);
      case (mode)
        0: rdy = 1'b1;
        1: rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      BEAT_READY = rdy;
      snap = {7'd0, BEAT_ADDR[31:2], BEAT_STRB, BEAT_INDEX};
      held = !rdy;
      tick();
      cyc++;
      if (rdy && v) got++;
      if (abort_after >= 0 && got == abort_after) begin
        #2 HRESET = 1'b1;
        #1;
        chk({tag, " rst_valid"}, 32'(BEAT_VALID), 32'd0);
        chk({tag, " rst_busy"}, 32'(BUSY), 32'd0);
        chk({tag, " rst_ready"}, 32'(REQ_READY), 32'd1);
        chk({tag, " rst_fields"}, {BEAT_ADDR[31:4], BEAT_STRB}, 32'd0);
        chk({tag, " rst_flags"}, 32'({BEAT_LAST, BEAT_INDEX, BEAT_WRITE}), 32'd0);
        #1 HRESET = 1'b0;
        BEAT_READY = 1'b0;
        tick();
        chk({tag, " post_rst_idle"}, 32'(BEAT_VALID), 32'd0);
        return;
      end
    end
    chk({tag, " beat_count"}, 32'(got), 32'(n));
    if (mode == 0) chk({tag, " cycles"}, 32'(cyc), 32'(n));
    BEAT_READY = 1'b0;
    chk({tag, " end_valid"}, 32'(BEAT_VALID), 32'd0);
    chk({tag, " end_ready"}, 32'(REQ_READY), 32'd1);
    chk({tag, " end_busy"}, 32'(BUSY), 32'd0);
  endtask

  vec_t vecs[$];
  logic [5:0] lens [6];

  initial begin
    logic [31:0] fa, la;
    logic [3:0] fs;
    int nb;
    logic [5:0] rl;

    lens = '{6'd1, 6'd2, 6'd4, 6'd8, 6'd16, 6'd32};
    vecs.push_back('{32'h0000_1003, 6'd1,  1'b1, 0, 32'h0000_1000, 32'h0000_1000, 4'b1000, 1});
    vecs.push_back('{32'h0000_2006, 6'd2,  1'b0, 0, 32'h0000_2004, 32'h0000_2004, 4'b1100, 1});
    vecs.push_back('{32'h0000_3000, 6'd32, 1'b1, 1, 32'h0000_3000, 32'h0000_301C, 4'b1111, 8});
    vecs.push_back('{32'hFFFF_FFF8, 6'd16, 1'b0, 0, 32'hFFFF_FFF8, 32'h0000_0004, 4'b1111, 4});
    vecs.push_back('{32'h0000_5005, 6'd4,  1'b1, 2, 32'h0000_5004, 32'h0000_5004, 4'b1111, 1});
    vecs.push_back('{32'h0000_600D, 6'd8,  1'b0, 0, 32'h0000_600C, 32'h0000_6010, 4'b1111, 2});
    vecs.push_back('{32'h0000_7001, 6'd2,  1'b1, 0, 32'h0000_7000, 32'h0000_7000, 4'b0011, 1});
`ifdef SPLITTER_ERR_EN
    vecs.push_back('{32'h0000_4002, 6'b000011, 1'b1, 0, 32'h0, 32'h0, 4'b0000, 0});
`else
    vecs.push_back('{32'h0000_4002, 6'b000011, 1'b1, 0, 32'h0000_4000, 32'h0000_4000, 4'b0100, 1});
`endif

    HRESET = 1'b1; REQ_VALID = 1'b0; REQ_ADDR = 32'd0; REQ_LENGTH = 6'd0;
    REQ_WRITE = 1'b0; BEAT_READY = 1'b0;
    #2;
    chk("reset req_ready", 32'(REQ_READY), 32'd1);
    chk("reset valid_busy", 32'({BEAT_VALID, BUSY}), 32'd0);
    chk("reset fields", BEAT_ADDR | 32'(BEAT_STRB), 32'd0);
    chk("reset flags", 32'({BEAT_WRITE, BEAT_LAST, BEAT_INDEX}), 32'd0);
`ifdef SPLITTER_ERR_EN
    chk("reset len_err", 32'(LEN_ERR), 32'd0);
`endif
    #10 HRESET = 1'b0;
    tick();

    foreach (vecs[i]) begin
      run_req(vecs[i].addr, vecs[i].len, vecs[i].write, vecs[i].mode, -1,
              $sformatf("vec%0d", i), fa, la, fs, nb);
      chk($sformatf("vec%0d nbeats", i), 32'(nb), 32'(vecs[i].exp_beats));
      if (vecs[i].exp_beats > 0) begin
        chk($sformatf("vec%0d first_addr", i), fa, vecs[i].exp_first);
        chk($sformatf("vec%0d last_addr", i), la, vecs[i].exp_last_addr);
        chk($sformatf("vec%0d first_strb", i), 32'(fs), 32'(vecs[i].exp_strb));
      end
      tick();
    end

    // Reset after two beats of an 8-beat request, then a clean 2-beat request
    run_req(32'h0000_8000, 6'd32, 1'b1, 0, 2, "abort", fa, la, fs, nb);
    run_req(32'h0000_9004, 6'd8, 1'b0, 0, -1, "after_abort", fa, la, fs, nb);
    chk("after_abort nbeats", 32'(nb), 32'd2);
    chk("after_abort last_addr", la, 32'h0000_9008);
    tick();

    for (int r = 0; r < 40; r++) begin
      rl = lens[$urandom_range(0, 5)];
      if ($urandom_range(0, 7) == 0) begin
        rl = 6'($urandom_range(0, 63));
        if ($countones(rl) == 1) rl = 6'b000110;
      end
      run_req($urandom, rl, 1'($urandom_range(0, 1)), 2, -1,
              $sformatf("rnd%0d", r), fa, la, fs, nb);
      chk($sformatf("rnd%0d nbeats", r), 32'(nb), 32'(exp_q.size()));
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ahb_apb_beat_splitter.md
# ahb_apb_beat_splitter

Downstream of the HSIZE byte-length encoder in the AHB-to-APB bridge. Accepts one AHB transfer request (address, one-hot byte length 1–32, direction) and breaks it into a sequence of 32-bit APB beats. Each beat carries a word address, a byte strobe, and a last flag, handed to the APB master FSM over a valid/ready handshake. One request is in flight at a time.

## Interface
- No parameters. APB beat width is fixed at 32 bits / 4 bytes. Maximum request is 32 bytes, i.e. 8 beats.
- HCLK  input  1  bridge clock; all state updates on its rising edge
- HRESET  input  1  asynchronous, active-high reset
- REQ_VALID  input  1  request present
- REQ_READY  output  1  splitter can accept a request
- REQ_ADDR  input  32  transfer start byte address
- REQ_LENGTH  input  6  byte count, one-hot: 1, 2, 4, 8, 16, 32 (the encoder's SIGNAL_LENGTH)
- REQ_WRITE  input  1  1 = write, 0 = read
- BEAT_VALID  output  1  beat fields valid
- BEAT_READY  input  1  APB FSM consumes the beat
- BEAT_ADDR  output  32  word-aligned beat address; [1:0] always 2'b00
- BEAT_STRB  output  4  active byte lanes
- BEAT_WRITE  output  1  captured REQ_WRITE
- BEAT_LAST  output  1  final beat of the request
- BEAT_INDEX  output  3  beat number within the request, 0-based
- BUSY  output  1  request in flight (state != IDLE)

## Operation
- FSM has two states: IDLE and ISSUE.
- IDLE:
  - REQ_READY=1, BEAT_VALID=0.
  - On REQ_VALID, capture addr, length and write, then go to ISSUE.
- ISSUE:
  - REQ_READY=0, BEAT_VALID=1.
  - Beat fields are held stable while BEAT_READY=0.
- Beat count: length ≤ 4 gives 1 beat; 8 gives 2; 16 gives 4; 32 gives 8. A beats-remaining counter is loaded with (count−1).
- First beat address: {REQ_ADDR[31:2], 2'b00}. Each subsequent beat adds 4, modulo 2^32, so 0xFFFF_FFFC wraps to 0x0000_0000.
- Strobe:
  - len 1: 4'b0001 << REQ_ADDR[1:0]
  - len 2: 4'b0011 << {REQ_ADDR[1], 1'b0}; ADDR[0] is ignored (forced alignment)
  - len ≥ 4: 4'b1111 on every beat; the low address bits are ignored
- Handshake: a beat transfers on a cycle with BEAT_VALID && BEAT_READY.
  - Non-last beat: index and address advance next cycle.
  - Last beat: return to IDLE next cycle.
- BEAT_LAST = (remaining == 0) while in ISSUE.
- REQ_VALID is ignored in ISSUE; the requester holds it until it sees REQ_READY.
- Invalid REQ_LENGTH (zero or not one-hot) is treated as 1 byte unless SPLITTER_ERR_EN is defined.
- Reset, including mid-request: asynchronous return to IDLE. The in-flight request is abandoned and no further beats are issued.

## Timing
- Reset values:
  - REQ_READY=1, BEAT_VALID=0, BUSY=0
  - BEAT_ADDR=0, BEAT_STRB=0, BEAT_WRITE=0, BEAT_LAST=0, BEAT_INDEX=0
  - LEN_ERR=0 (when present)
- Request accepted at edge k: BEAT_VALID=1 and BUSY=1 from cycle k+1. Accept-to-first-beat latency is 1 cycle.
- With BEAT_READY held at 1, an N-beat request issues beats on N consecutive cycles. REQ_READY returns 1 in the cycle after the last beat transfers.
- Request throughput: at best N+1 cycles per request (the one IDLE cycle is required).
- All outputs are registered. No combinational path runs from BEAT_READY or REQ_VALID to any output.

## Configuration
- SPLITTER_ERR_EN defined:
  - Adds output LEN_ERR (1 bit).
  - An invalid REQ_LENGTH is still accepted (REQ_READY handshake completes), but the FSM stays in IDLE and issues no beats.
  - LEN_ERR pulses high for exactly one cycle, the cycle after acceptance.
- SPLITTER_ERR_EN undefined: no LEN_ERR port; invalid lengths issue one beat as a 1-byte transfer.

## Test plan
- Reset, then REQ_ADDR=0x1003, LEN=1, write, BEAT_READY=1 -> one beat: ADDR=0x1000, STRB=4'b1000, LAST=1, WRITE=1; REQ_READY high 2 cycles after accept.
- ADDR=0x2006, LEN=2, read -> one beat: ADDR=0x2004, STRB=4'b1100, LAST=1, WRITE=0.
- ADDR=0x3000, LEN=32, BEAT_READY toggling 1,0,1,0… -> 8 beats at ADDR 0x3000…0x301C, STRB=F, INDEX 0…7, LAST only on index 7; fields stable during READY=0 cycles.
- ADDR=0xFFFF_FFF8, LEN=16 -> beat addresses FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Assert HRESET after beat 2 of a LEN=32 request -> BEAT_VALID=0 and BUSY=0 immediately; a new LEN=8 request afterwards yields exactly 2 clean beats.
- LEN=6'b000011: without the macro -> 1 beat, 1-byte strobe; with SPLITTER_ERR_EN -> no beats, LEN_ERR high for 1 cycle, REQ_READY stays 1.
